e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: E_MDU_start  input  1  launches the operation encoded on E_MDUop this cycle.
REQ-004 SHALL have port: E_MDUop  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu.
REQ-005 SHALL have port: E_rs_data  input  32  forwarded rs operand.
REQ-006 SHALL have port: E_rt_data  input  32  forwarded rt operand.
REQ-007 SHALL have port: E_MDU_busy  output  1  high while a mult/div-class op is in flight.
REQ-008 SHALL have port: E_MDUout  output  32  mfhi/mflo read data, consumed by the E/M pipeline register.

Function
REQ-009 Mult-class ops (1, 2, 9-12) SHALL take 5 cycles; div-class ops (3, 4) SHALL take 10 cycles.
REQ-010 Launch condition: E_MDU_start=1, op in {1-4, 9-12}, E_MDU_busy=0; operands SHALL be sampled at that edge.
REQ-011 After launch, E_MDU_busy SHALL be 1 for exactly N consecutive cycles (N per REQ-009); the internal down-counter loads N and decrements once per cycle.
REQ-012 HI/LO SHALL update on the edge where the counter reaches 0, i.e. together with busy deasserting; HI/LO SHALL hold their old values throughout the busy window.
REQ-013 mult: {HI,LO} = signed rs*rt; multu: unsigned 64-bit product.
REQ-014 madd/maddu: {HI,LO} += product; msub/msubu: {HI,LO} -= product; 64-bit wrap-around, signedness as op name.
REQ-015 div: LO = signed quotient, HI = signed remainder (truncate toward zero, remainder takes dividend sign); divu: unsigned.
REQ-016 Divide by zero: the full 10-cycle busy window SHALL run, and HI/LO SHALL remain unchanged.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-018 mthi/mtlo with E_MDU_start=1 and busy=0 SHALL write rs into HI/LO at that edge; busy SHALL stay 0.
REQ-019 E_MDU_start while busy=1 SHALL be ignored entirely; the hazard unit is required to stall instead.
REQ-020 E_MDUout SHALL be combinational: HI when op=5, LO when op=6, else 0; it is independent of start and busy.
REQ-021 Op 0, and codes 13-15, SHALL be no-ops.
REQ-022 A start with start=1 and a mult/div op SHALL make the stall condition (start|busy) valid the same cycle; busy itself SHALL rise on the next cycle.

Reset
REQ-023 On reset: HI=0, LO=0, counter=0, E_MDU_busy=0, and any in-flight result discarded.
REQ-024 Reset asserted mid-operation SHALL abort the operation; no HI/LO write occurs afterwards.
REQ-025 Reset SHALL take priority over a simultaneous start.

Configuration
REQ-026 Macro MDU_MADD_EN: when defined, ops 9-12 SHALL behave per REQ-014; when undefined, ops 9-12 SHALL be no-ops (no busy, no HI/LO change) and the accumulate datapath is absent.

Verification
REQ-027 mult rs=0xFFFFFFFE (-2), rt=3 -> busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi/mflo then return these values.
REQ-028 divu rs=100, rt=7 -> busy=1 for 10 cycles, then LO=14, HI=2; div rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-029 Sequence mthi 0x1234, then div by 0 -> busy for 10 cycles, HI still 0x1234, LO unchanged.
REQ-030 Launch mult; in busy cycle 2, start divu -> the divu is ignored, and the mult result alone is written at the end of cycle 5.
REQ-031 Launch div; assert reset in busy cycle 4 -> busy=0 and HI=LO=0 the next cycle, and no later write occurs.
REQ-032 With MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, maddu rs=1, rt=1 -> HI=1, LO=0; without the macro, HI/LO are unchanged and busy stays 0.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: multiply/divide unit holding the HI/LO register pair.
//
// Mult-class ops (mult, multu and, when built in, madd/maddu/msub/msubu)
// occupy the unit for 5 cycles. Div-class ops (div, divu) occupy it for
// 10 cycles. HI/LO change only on the edge that ends the busy window.
// mthi/mtlo write immediately. mfhi/mflo are read combinationally on E_MDUout.
//
// Build option: define MDU_MADD_EN to enable the multiply-accumulate ops
// (9-12). Without it those codes are no-ops and the accumulate adder is absent.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset
//   E_MDU_start  launch the op on E_MDUop this cycle
//   E_MDUop      op code (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi,
//                6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu)
//   E_rs_data    forwarded rs operand
//   E_rt_data    forwarded rt operand
//   E_MDU_busy   high while a mult/div-class op is in flight
//   E_MDUout     HI for mfhi, LO for mflo, otherwise 0 (combinational)
module e_mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_MDU_start,
    input  logic [3:0]  E_MDUop,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDUout
);

    localparam int unsigned XLEN        = 32;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    logic [XLEN-1:0]   hi_q, lo_q;
    logic [XLEN-1:0]   rs_q, rt_q;
    logic [3:0]        op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;

    logic              is_mult_c, is_div_c, launch_c;
    logic              is_signed_c;
    logic [2*XLEN-1:0] a_ext_c, b_ext_c, prod_c;
    logic              a_neg_c, b_neg_c, div_ok_c;
    logic [XLEN-1:0]   a_mag_c, b_mag_c, q_mag_c, r_mag_c, quo_c, rem_c;
    logic [2*XLEN-1:0] res_c;
    logic              wr_c;

    assign E_MDU_busy = busy_q;

    // Decode the incoming op for launch.
    always_comb begin
        is_mult_c = (E_MDUop == OP_MULT) || (E_MDUop == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mult_c = is_mult_c || (E_MDUop == OP_MADD) || (E_MDUop == OP_MADDU)
                              || (E_MDUop == OP_MSUB) || (E_MDUop == OP_MSUBU);
`endif
        is_div_c  = (E_MDUop == OP_DIV) || (E_MDUop == OP_DIVU);
        launch_c  = E_MDU_start && !busy_q && (is_mult_c || is_div_c);
    end

    // Signedness of the latched op.
    always_comb begin
        is_signed_c = (op_q == OP_MULT) || (op_q == OP_DIV);
`ifdef MDU_MADD_EN
        is_signed_c = is_signed_c || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
    end

    // 64-bit product; the low 64 bits of the extended operands' product are
    // correct for both signed and unsigned interpretations.
    always_comb begin
        a_ext_c = {{XLEN{is_signed_c & rs_q[XLEN-1]}}, rs_q};
        b_ext_c = {{XLEN{is_signed_c & rt_q[XLEN-1]}}, rt_q};
        prod_c  = a_ext_c * b_ext_c;
    end

    // Divide on magnitudes, then restore signs. Working in unsigned magnitudes
    // makes 0x80000000 / -1 fall out naturally as 0x80000000 rem 0.
    always_comb begin
        div_ok_c = (rt_q != '0);
        a_neg_c  = is_signed_c & rs_q[XLEN-1];
        b_neg_c  = is_signed_c & rt_q[XLEN-1];
        a_mag_c  = a_neg_c ? (~rs_q + XLEN'(1)) : rs_q;
        b_mag_c  = b_neg_c ? (~rt_q + XLEN'(1)) : rt_q;
        if (!div_ok_c) begin
            b_mag_c = XLEN'(1);
        end
        q_mag_c  = a_mag_c / b_mag_c;
        r_mag_c  = a_mag_c % b_mag_c;
        quo_c    = (a_neg_c ^ b_neg_c) ? (~q_mag_c + XLEN'(1)) : q_mag_c;
        rem_c    = a_neg_c ? (~r_mag_c + XLEN'(1)) : r_mag_c;
    end

    // Result to commit at the end of the busy window.
    always_comb begin
        res_c = {hi_q, lo_q};
        wr_c  = 1'b0;
        case (op_q)
            OP_MULT, OP_MULTU: begin
                res_c = prod_c;
                wr_c  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_c = {rem_c, quo_c};
                wr_c  = div_ok_c;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                res_c = {hi_q, lo_q} + prod_c;
                wr_c  = 1'b1;
            end
            OP_MSUB, OP_MSUBU: begin
                res_c = {hi_q, lo_q} - prod_c;
                wr_c  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // HI/LO, operand latches and busy countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (launch_c) begin
            rs_q   <= E_rs_data;
            rt_q   <= E_rt_data;
            op_q   <= E_MDUop;
            cnt_q  <= is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            // Starts during busy are ignored; the hazard unit stalls instead.
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
                if (wr_c) begin
                    {hi_q, lo_q} <= res_c;
                end
            end
        end else if (E_MDU_start) begin
            if (E_MDUop == OP_MTHI) begin
                hi_q <= E_rs_data;
            end else if (E_MDUop == OP_MTLO) begin
                lo_q <= E_rs_data;
            end
        end
    end

    // mfhi/mflo read port.
    always_comb begin
        E_MDUout = '0;
        case (E_MDUop)
            OP_MFHI: E_MDUout = hi_q;
            OP_MFLO: E_MDUout = lo_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu: directed vectors, a behavioural HI/LO model checked
// every cycle, and literal expectations for the key results.
module tb_e_mdu;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        E_MDU_start = 1'b0;
    logic [3:0]  E_MDUop = 4'd0;
    logic [31:0] E_rs_data = 32'd0;
    logic [31:0] E_rt_data = 32'd0;
    logic        E_MDU_busy;
    logic [31:0] E_MDUout;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    e_mdu dut (
        .clk         (clk),
        .reset       (reset),
        .E_MDU_start (E_MDU_start),
        .E_MDUop     (E_MDUop),
        .E_rs_data   (E_rs_data),
        .E_rt_data   (E_rt_data),
        .E_MDU_busy  (E_MDU_busy),
        .E_MDUout    (E_MDUout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining busy cycles plus the result to commit.
    logic [31:0] hi_m = 32'd0, lo_m = 32'd0;
    logic [31:0] phi_m = 32'd0, plo_m = 32'd0;
    int          rem_m = 0;
    bit          pwr_m = 1'b0;
    logic [63:0] acc_m, p_m;
    longint      a_m, b_m, q_m, r_m;

    always @(posedge clk) begin
        if (reset) begin
            hi_m = 32'd0; lo_m = 32'd0; rem_m = 0; pwr_m = 1'b0;
        end else if (rem_m > 0) begin
            rem_m--;
            if (rem_m == 0 && pwr_m) begin
                hi_m = phi_m; lo_m = plo_m;
            end
        end else if (E_MDU_start) begin
            acc_m = {hi_m, lo_m};
            case (E_MDUop)
                OP_MULT: begin
                    p_m = 64'(longint'($signed(E_rs_data)) * longint'($signed(E_rt_data)));
                    {phi_m, plo_m} = p_m; pwr_m = 1'b1; rem_m = 5;
                end
                OP_MULTU: begin
                    p_m = {32'd0, E_rs_data} * {32'd0, E_rt_data};
                    {phi_m, plo_m} = p_m; pwr_m = 1'b1; rem_m = 5;
                end
                OP_DIV, OP_DIVU: begin
                    if (E_MDUop == OP_DIV) begin
                        a_m = longint'($signed(E_rs_data)); b_m = longint'($signed(E_rt_data));
                    end else begin
                        a_m = longint'({32'd0, E_rs_data}); b_m = longint'({32'd0, E_rt_data});
                    end
                    pwr_m = (b_m != 0);
                    if (pwr_m) begin
                        q_m = a_m / b_m; r_m = a_m % b_m;
                        phi_m = r_m[31:0]; plo_m = q_m[31:0];
                    end
                    rem_m = 10;
                end
                OP_MTHI: hi_m = E_rs_data;
                OP_MTLO: lo_m = E_rs_data;
`ifdef MDU_MADD_EN
                OP_MADD, OP_MSUB: begin
                    p_m = 64'(longint'($signed(E_rs_data)) * longint'($signed(E_rt_data)));
                    {phi_m, plo_m} = (E_MDUop == OP_MADD) ? acc_m + p_m : acc_m - p_m;
                    pwr_m = 1'b1; rem_m = 5;
                end
                OP_MADDU, OP_MSUBU: begin
                    p_m = {32'd0, E_rs_data} * {32'd0, E_rt_data};
                    {phi_m, plo_m} = (E_MDUop == OP_MADDU) ? acc_m + p_m : acc_m - p_m;
                    pwr_m = 1'b1; rem_m = 5;
                end
`endif
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_vs_model", 32'(E_MDU_busy), 32'(rem_m > 0));
            check("out_vs_model", E_MDUout,
                  (E_MDUop == OP_MFHI) ? hi_m : (E_MDUop == OP_MFLO) ? lo_m : 32'd0);
        end
    end

    // One-cycle start pulse; afterwards E_MDUop shows 'watch' with start low.
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [3:0] watch);
        @(posedge clk); #1;
        E_MDU_start = 1'b1; E_MDUop = op; E_rs_data = rs; E_rt_data = rt;
        @(posedge clk); #1;
        E_MDU_start = 1'b0; E_MDUop = watch;
    endtask

    task automatic count_busy(input string nm, input int exp);
        int n = 0;
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (E_MDU_busy) n++;
            else done = 1'b1;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s: busy still high after 40 cycles", nm);
        end else begin
            check(nm, 32'(n), 32'(exp));
        end
    endtask

    task automatic rd(input logic [3:0] op, input logic [31:0] exp, input string nm);
        @(posedge clk); #1;
        E_MDUop = op;
        @(negedge clk);
        check(nm, E_MDUout, exp);
    endtask

    logic [3:0] noop_codes [3] = '{4'd0, 4'd13, 4'd15};

    initial begin
        repeat (2) @(posedge clk);
        #1; reset = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(E_MDU_busy), 32'd0);
        rd(OP_MFHI, 32'h0, "reset_hi");
        rd(OP_MFLO, 32'h0, "reset_lo");

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, OP_MFHI);
        count_busy("mult_busy", 5);
        rd(OP_MFHI, 32'hFFFF_FFFF, "mult_hi");
        rd(OP_MFLO, 32'hFFFF_FFFA, "mult_lo");

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MFLO);
        count_busy("multu_busy", 5);
        rd(OP_MFHI, 32'hFFFF_FFFE, "multu_hi");
        rd(OP_MFLO, 32'h0000_0001, "multu_lo");

        issue(OP_DIVU, 32'd100, 32'd7, OP_MFLO);
        count_busy("divu_busy", 10);
        rd(OP_MFLO, 32'd14, "divu_lo");
        rd(OP_MFHI, 32'd2, "divu_hi");

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, OP_MFHI);
        count_busy("div_busy", 10);
        rd(OP_MFLO, 32'hFFFF_FFFD, "div_lo");
        rd(OP_MFHI, 32'hFFFF_FFFF, "div_hi");

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, OP_MFLO);
        count_busy("div_ovf_busy", 10);
        rd(OP_MFLO, 32'h8000_0000, "div_ovf_lo");
        rd(OP_MFHI, 32'h0, "div_ovf_hi");

        issue(OP_MTHI, 32'h1234, 32'd0, OP_MFHI);
        count_busy("mthi_busy", 0);
        rd(OP_MFHI, 32'h1234, "mthi_hi");
        issue(OP_DIV, 32'd55, 32'd0, OP_MFHI);
        count_busy("div0_busy", 10);
        rd(OP_MFHI, 32'h1234, "div0_hi");
        rd(OP_MFLO, 32'h8000_0000, "div0_lo");

        // A divu started in busy cycle 2 of a mult must be dropped.
        issue(OP_MULT, 32'd6, 32'd7, OP_MFLO);
        @(posedge clk); #1;
        E_MDU_start = 1'b1; E_MDUop = OP_DIVU; E_rs_data = 32'd100; E_rt_data = 32'd7;
        @(posedge clk); #1;
        E_MDU_start = 1'b0; E_MDUop = OP_MFLO;
        count_busy("ignore_busy_rest", 3);
        rd(OP_MFLO, 32'd42, "ignore_lo");
        rd(OP_MFHI, 32'd0, "ignore_hi");

        // Reset in busy cycle 4 aborts the divide.
        issue(OP_DIVU, 32'd100, 32'd7, OP_MFHI);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(E_MDU_busy), 32'd0);
        rd(OP_MFHI, 32'd0, "abort_hi");
        rd(OP_MFLO, 32'd0, "abort_lo");
        repeat (12) @(posedge clk);
        rd(OP_MFHI, 32'd0, "abort_late_hi");
        rd(OP_MFLO, 32'd0, "abort_late_lo");

        // Reset wins over a simultaneous start.
        @(posedge clk); #1;
        reset = 1'b1; E_MDU_start = 1'b1; E_MDUop = OP_MULT; E_rs_data = 32'd3; E_rt_data = 32'd3;
        @(posedge clk); #1;
        reset = 1'b0; E_MDU_start = 1'b0; E_MDUop = OP_MFLO;
        count_busy("rst_prio_busy", 0);
        rd(OP_MFLO, 32'd0, "rst_prio_lo");

        issue(OP_MTLO, 32'd5, 32'd0, OP_NONE);
        foreach (noop_codes[i]) begin
            issue(noop_codes[i], 32'd9, 32'd9, OP_MFLO);
            count_busy("noop_busy", 0);
            rd(OP_MFLO, 32'd5, "noop_lo");
        end

        issue(OP_MTHI, 32'd0, 32'd0, OP_NONE);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0, OP_NONE);
        issue(OP_MADDU, 32'd1, 32'd1, OP_MFHI);
`ifdef MDU_MADD_EN
        count_busy("maddu_busy", 5);
        rd(OP_MFHI, 32'd1, "maddu_hi");
        rd(OP_MFLO, 32'd0, "maddu_lo");
        issue(OP_MSUB, 32'd2, 32'd3, OP_MFLO);
        count_busy("msub_busy", 5);
        rd(OP_MFHI, 32'd0, "msub_hi");
        rd(OP_MFLO, 32'hFFFF_FFFA, "msub_lo");
`else
        count_busy("maddu_busy", 0);
        rd(OP_MFHI, 32'd0, "maddu_hi");
        rd(OP_MFLO, 32'hFFFF_FFFF, "maddu_lo");
        issue(OP_MSUB, 32'd2, 32'd3, OP_MFLO);
        count_busy("msub_busy", 0);
        rd(OP_MFHI, 32'd0, "msub_hi");
        rd(OP_MFLO, 32'hFFFF_FFFF, "msub_lo");
`endif
        issue(OP_MADD, 32'd0, 32'd0, OP_NONE);
        issue(OP_MSUBU, 32'd0, 32'd0, OP_NONE);
        repeat (12) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
